text_ram_writer: RTL and testbench
==================================

Name: text_ram_writer

Overview:
- Write-side master for the dual-port character RAM that feeds the text video renderer.
- Accepts a byte stream of characters over a valid/ready handshake and maintains a text cursor.
- Drives the RAM write port (write_en/waddr/din); the renderer owns the read port.
- Also performs a full-screen clear sweep on request.

Parameters:
- COL_BITS, 4, log2 of columns per row (16 columns)
- ROW_BITS, 3, log2 of rows (8 rows)
- addr_width, COL_BITS+ROW_BITS (7), RAM address width; waddr = {row, col}
- data_width, 8, character code width
- BLANK, 8'h20, code written by clear and backspace

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- ch_valid  in  1  character byte valid
- ch_data  in  data_width  character byte
- ch_ready  out  1  writer can accept a byte this cycle
- clear_req  in  1  one-cycle pulse: blank the screen and home the cursor
- busy  out  1  clear sweep in progress
- write_en  out  1  RAM write strobe
- waddr  out  addr_width  RAM write address
- din  out  data_width  RAM write data
- cursor_col  out  COL_BITS  current cursor column
- cursor_row  out  ROW_BITS  current cursor row

Behaviour:
- Reset: asynchronous (rstn low) and active-low, single clock domain clk.
- Reset values: state=IDLE, write_en=0, waddr=0, din=0, cursor_col=0, cursor_row=0, busy=0.
- Output timing: write_en/waddr/din are registered; a write occurs one cycle after the accepting edge, and write_en is high for exactly one cycle per write.
- ch_ready is combinational: ch_ready = (state==IDLE) && !clear_req. A byte is accepted on a rising edge with ch_valid && ch_ready.
- FSM IDLE:
  - clear_req=1 -> CLEAR with sweep counter=0; busy=1 from the next cycle. clear_req takes priority over a simultaneous ch_valid, which is not accepted.
  - Accepted byte -> handled as below; the FSM stays in IDLE. Throughput is one byte per cycle.
- FSM CLEAR:
  - Each cycle: write_en=1, waddr=counter, din=BLANK, counter+1.
  - After address 2^addr_width-1 is written, go to IDLE, set cursor to (0,0), busy=0.
  - Sweep length is 128 cycles at defaults.
  - clear_req during CLEAR is ignored; the sweep is not restarted.
- Byte handling in IDLE:
  - 0x20..0x7E: write byte at {row,col}, then advance the cursor.
  - 0x0A (LF): col=0, row+1; no write.
  - 0x0D (CR): col=0; no write.
  - 0x08 (BS): if col>0, col-1 and write BLANK at the new position. If col==0, no-op; no change of row.
  - Any other code: accepted and discarded; no write, cursor unchanged.
- Advance: col+1. When col==2^COL_BITS-1, col=0 and row+1.
- Row increment wraps: 2^ROW_BITS-1 -> 0. There is no scrolling, and existing text is overwritten.
- The cursor outputs reflect the updated position in the same cycle that the corresponding write_en is high.
- Reset mid-sweep aborts immediately. RAM contents are left partially cleared, and outputs return to their reset values.

Optional Feature:
- Macro: TEXT_WRITER_TAB_EN.
- When defined, 0x09 (TAB) moves col to the next multiple of 4 with no write.
  - If col >= 2^COL_BITS-4, col=0 and row+1, with wrap.
- When undefined, 0x09 is treated as an unknown code: accepted, no write, cursor unchanged.

Test Plan:
- Release rstn, send "A" (0x41) -> next cycle write_en=1, waddr=0x00, din=0x41; cursor_col=1, cursor_row=0.
- Cursor at (15,0), send 0x42 -> waddr=0x0F, din=0x42; cursor becomes (0,1). Cursor at (15,7), send 0x43 -> waddr=0x7F; cursor becomes (0,0).
- Cursor at (5,2), send 0x08 -> write_en=1, waddr=0x24, din=0x20, cursor (4,2). With cursor (0,3), send 0x08 -> no write, cursor (0,3).
- Pulse clear_req while ch_valid=1 -> ch_ready=0 that cycle, byte not consumed. Then 128 consecutive writes with waddr 0x00..0x7F, din=0x20, busy=1 throughout. Afterwards busy=0, cursor (0,0), ch_ready=1.
- Cursor at (9,4), send 0x0A then 0x0D -> cursor (0,5) then (0,5), with no write_en pulses. Send 0x01 -> no write, cursor unchanged.
- With TEXT_WRITER_TAB_EN defined: cursor (5,0), send 0x09 -> cursor (8,0), no write. Cursor (13,0), send 0x09 -> cursor (0,1).

Source files
------------

// File: rtl/text_ram_writer.sv
// Write-side master for the text-mode character RAM: cursor tracking, control codes, clear sweep.
// Optional build macro TEXT_WRITER_TAB_EN enables TAB (0x09) handling to the next 4-column stop.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | accepting character bytes, one per cycle
//   CLEAR | sweeping BLANK across every RAM address, then homing cursor
module text_ram_writer #(
    parameter int                    COL_BITS   = 4,
    parameter int                    ROW_BITS   = 3,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] BLANK      = 8'h20
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             ch_valid,
    input  logic [DATA_WIDTH-1:0]            ch_data,
    output logic                             ch_ready,
    input  logic                             clear_req,
    output logic                             busy,
    output logic                             write_en,
    output logic [COL_BITS+ROW_BITS-1:0]     waddr,
    output logic [DATA_WIDTH-1:0]            din,
    output logic [COL_BITS-1:0]              cursor_col,
    output logic [ROW_BITS-1:0]              cursor_row
);

    localparam int ADDR_WIDTH = COL_BITS + ROW_BITS;
    localparam int COLS       = 1 << COL_BITS;

    localparam logic [DATA_WIDTH-1:0] CH_BS    = DATA_WIDTH'(8'h08);
    localparam logic [DATA_WIDTH-1:0] CH_LF    = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] CH_FIRST = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0] CH_LAST  = DATA_WIDTH'(8'h7E);
`ifdef TEXT_WRITER_TAB_EN
    localparam logic [DATA_WIDTH-1:0] CH_TAB   = DATA_WIDTH'(8'h09);
    localparam logic [COL_BITS-1:0]   TAB_LAST = COL_BITS'(COLS - 4);
`endif

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   sweep_cnt, sweep_cnt_nxt;
    logic                    busy_nxt;
    logic                    we_nxt;
    logic [ADDR_WIDTH-1:0]   waddr_nxt;
    logic [DATA_WIDTH-1:0]   din_nxt;
    logic [COL_BITS-1:0]     col_nxt;
    logic [ROW_BITS-1:0]     row_nxt;
    logic [ADDR_WIDTH-1:0]   pos_inc;
    logic [COL_BITS-1:0]     col_dec;

    assign ch_ready = (state == IDLE) && !clear_req;
    assign pos_inc  = {cursor_row, cursor_col} + 1'b1;
    assign col_dec  = cursor_col - 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            sweep_cnt  <= '0;
            busy       <= 1'b0;
            write_en   <= 1'b0;
            waddr      <= '0;
            din        <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            state      <= state_nxt;
            sweep_cnt  <= sweep_cnt_nxt;
            busy       <= busy_nxt;
            write_en   <= we_nxt;
            waddr      <= waddr_nxt;
            din        <= din_nxt;
            cursor_col <= col_nxt;
            cursor_row <= row_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        busy_nxt      = busy;
        we_nxt        = 1'b0;
        waddr_nxt     = waddr;
        din_nxt       = din;
        col_nxt       = cursor_col;
        row_nxt       = cursor_row;

        case (state)
            IDLE: begin
                if (clear_req) begin
                    // first blank goes out in the cycle right after the request
                    state_nxt     = CLEAR;
                    busy_nxt      = 1'b1;
                    sweep_cnt_nxt = '0;
                    we_nxt        = 1'b1;
                    waddr_nxt     = '0;
                    din_nxt       = BLANK;
                end else if (ch_valid) begin
                    if (ch_data >= CH_FIRST && ch_data <= CH_LAST) begin
                        we_nxt               = 1'b1;
                        waddr_nxt            = {cursor_row, cursor_col};
                        din_nxt              = ch_data;
                        {row_nxt, col_nxt}   = pos_inc;
                    end else if (ch_data == CH_LF) begin
                        col_nxt = '0;
                        row_nxt = cursor_row + 1'b1;
                    end else if (ch_data == CH_CR) begin
                        col_nxt = '0;
                    end else if (ch_data == CH_BS) begin
                        if (cursor_col != '0) begin
                            col_nxt   = col_dec;
                            we_nxt    = 1'b1;
                            waddr_nxt = {cursor_row, col_dec};
                            din_nxt   = BLANK;
                        end
`ifdef TEXT_WRITER_TAB_EN
                    end else if (ch_data == CH_TAB) begin
                        if (cursor_col >= TAB_LAST) begin
                            col_nxt = '0;
                            row_nxt = cursor_row + 1'b1;
                        end else begin
                            col_nxt = (cursor_col | COL_BITS'(3)) + 1'b1;
                        end
`endif
                    end
                end
            end
            CLEAR: begin
                if (sweep_cnt == '1) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    col_nxt   = '0;
                    row_nxt   = '0;
                end else begin
                    sweep_cnt_nxt = sweep_cnt + 1'b1;
                    we_nxt        = 1'b1;
                    waddr_nxt     = sweep_cnt + 1'b1;
                    din_nxt       = BLANK;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_ram_writer.sv
// Randomized self-checking bench for text_ram_writer against a linear-position cursor model.
// Honours TEXT_WRITER_TAB_EN the same way the design does.
module tb_text_ram_writer;

    localparam int COLS  = 16;
    localparam int ROWS  = 8;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ch_valid;
    logic [7:0] ch_data;
    logic       ch_ready;
    logic       clear_req;
    logic       busy;
    logic       write_en;
    logic [6:0] waddr;
    logic [7:0] din;
    logic [3:0] cursor_col;
    logic [2:0] cursor_row;

    int errors = 0;
    int checks = 0;
    int m_col  = 0;
    int m_row  = 0;

    text_ram_writer dut (
        .clk        (clk),
        .rstn       (rstn),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .clear_req  (clear_req),
        .busy       (busy),
        .write_en   (write_en),
        .waddr      (waddr),
        .din        (din),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    // reference: cursor as a linear screen position, codes interpreted directly
    task automatic model(input logic [7:0] b, output logic we, output int addr, output int d);
        int pos;
        we = 1'b0; addr = 0; d = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            we   = 1'b1;
            addr = m_row * COLS + m_col;
            d    = b;
            pos  = (addr + 1) % CELLS;
            m_col = pos % COLS;
            m_row = pos / COLS;
        end else if (b == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col = m_col - 1;
                we    = 1'b1;
                addr  = m_row * COLS + m_col;
                d     = 32;
            end
`ifdef TEXT_WRITER_TAB_EN
        end else if (b == 8'h09) begin
            m_col = (m_col / 4 + 1) * 4;
            if (m_col >= COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end
`endif
        end
    endtask

    // one cycle: present (v,b), clock it, then check the registered result
    task automatic step(input logic v, input logic [7:0] b);
        logic we;
        int   addr, d;
        ch_valid  = v;
        ch_data   = b;
        clear_req = 1'b0;
        #1;
        checks++;
        if (ch_ready !== 1'b1) begin
            errors++;
            $display("FAIL ch_ready_idle: got %b want 1", ch_ready);
        end
        @(posedge clk);
        #1;
        we = 1'b0; addr = 0; d = 0;
        if (v) model(b, we, addr, d);
        checks++;
        if (write_en !== we) begin
            errors++;
            $display("FAIL write_en byte=%02h: got %b want %b", b, write_en, we);
        end
        if (we) begin
            checks++;
            if (int'(waddr) != addr || int'(din) != d || $isunknown({waddr, din})) begin
                errors++;
                $display("FAIL write byte=%02h: got waddr=%02h din=%02h want waddr=%02h din=%02h",
                         b, waddr, din, addr, d);
            end
        end
        checks++;
        if (int'(cursor_col) != m_col || int'(cursor_row) != m_row || $isunknown({cursor_col, cursor_row})) begin
            errors++;
            $display("FAIL cursor byte=%02h: got (%0d,%0d) want (%0d,%0d)",
                     b, cursor_col, cursor_row, m_col, m_row);
        end
        ch_valid = 1'b0;
    endtask

    task automatic goto_pos(input int c, input int r);
        step(1'b1, 8'h0D);
        repeat (ROWS) if (m_row != r) step(1'b1, 8'h0A);
        repeat (c) step(1'b1, 8'h2E);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (write_en !== 1'b0 || waddr !== 7'h00 || din !== 8'h00 || busy !== 1'b0 ||
            cursor_col !== 4'd0 || cursor_row !== 3'd0) begin
            errors++;
            $display("FAIL %s: got we=%b waddr=%02h din=%02h busy=%b cur=(%0d,%0d) want all zero",
                     tag, write_en, waddr, din, busy, cursor_col, cursor_row);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; ch_valid = 1'b0; ch_data = 8'h00; clear_req = 1'b0;
        #13;
        check_reset_outputs("reset_values");
        checks++;
        if (ch_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ch_ready: got %b want 1", ch_ready);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        m_col = 0; m_row = 0;
    endtask

    task automatic test_first_char();
        step(1'b1, 8'h41);
        checks++;
        if (waddr !== 7'h00 || din !== 8'h41 || cursor_col !== 4'd1) begin
            errors++;
            $display("FAIL first_char: got waddr=%02h din=%02h col=%0d want 00 41 1", waddr, din, cursor_col);
        end
    endtask

    task automatic test_wrap();
        goto_pos(15, 0);
        step(1'b1, 8'h42);
        goto_pos(15, 7);
        step(1'b1, 8'h43);
        checks++;
        if (waddr !== 7'h7F || cursor_col !== 4'd0 || cursor_row !== 3'd0) begin
            errors++;
            $display("FAIL screen_wrap: got waddr=%02h cur=(%0d,%0d) want 7f (0,0)", waddr, cursor_col, cursor_row);
        end
    endtask

    task automatic test_backspace();
        goto_pos(5, 2);
        step(1'b1, 8'h08);
        goto_pos(0, 3);
        step(1'b1, 8'h08);
    endtask

    task automatic test_control();
        goto_pos(9, 4);
        step(1'b1, 8'h0A);
        step(1'b1, 8'h0D);
        step(1'b1, 8'h01);
        step(1'b1, 8'h7F);
        step(1'b1, 8'h1F);
    endtask

    task automatic test_tab();
        goto_pos(5, 0);
        step(1'b1, 8'h09);
        goto_pos(13, 0);
        step(1'b1, 8'h09);
        goto_pos(11, 7);
        step(1'b1, 8'h09);
    endtask

    task automatic test_clear();
        int bad = 0;
        ch_valid = 1'b1; ch_data = 8'h55; clear_req = 1'b1;
        #1;
        checks++;
        if (ch_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_blocks_ready: got %b want 0", ch_ready);
        end
        @(posedge clk);
        #1;
        clear_req = 1'b0; ch_valid = 1'b0;
        for (int i = 0; i < CELLS; i++) begin
            if (i == 50) clear_req = 1'b1;
            if (i == 51) clear_req = 1'b0;
            checks++;
            if (write_en !== 1'b1 || int'(waddr) != i || din !== 8'h20 || busy !== 1'b1 || ch_ready !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL clear_sweep[%0d]: got we=%b waddr=%02h din=%02h busy=%b rdy=%b want 1 %02h 20 1 0",
                             i, write_en, waddr, din, busy, ch_ready, i);
            end
            @(posedge clk);
            #1;
        end
        m_col = 0; m_row = 0;
        checks++;
        if (write_en !== 1'b0 || busy !== 1'b0 || ch_ready !== 1'b1 || cursor_col !== 4'd0 || cursor_row !== 3'd0) begin
            errors++;
            $display("FAIL clear_done: got we=%b busy=%b rdy=%b cur=(%0d,%0d) want 0 0 1 (0,0)",
                     write_en, busy, ch_ready, cursor_col, cursor_row);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         k;
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                0:       b = 8'h0A;
                1:       b = 8'h0D;
                2, 3:    b = 8'h08;
                4:       b = 8'h09;
                5:       b = 8'($urandom_range(0, 255));
                default: b = 8'($urandom_range(32, 126));
            endcase
            step(($urandom_range(0, 4) != 0), b);
        end
    endtask

    task automatic test_reset_mid_sweep();
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("reset_mid_sweep");
        #3;
        rstn = 1'b1;
        m_col = 0; m_row = 0;
        @(posedge clk);
        #1;
        checks++;
        if (write_en !== 1'b0 || busy !== 1'b0 || ch_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_abort: got we=%b busy=%b rdy=%b want 0 0 1", write_en, busy, ch_ready);
        end
        step(1'b1, 8'h5A);
    endtask

    initial begin
        test_reset();
        test_first_char();
        test_wrap();
        test_backspace();
        test_control();
        test_tab();
        test_clear();
        test_random();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
